// File: rtl/approx_err_pkg.sv
// Shared widths and FSM state type for the approximate-multiplier error accumulator.
package approx_err_pkg;

    localparam int W_DEF     = 16;
    localparam int CNT_W_DEF = 16;
    localparam int SAE_W_DEF = W_DEF + CNT_W_DEF;
    localparam int SSE_W_DEF = 2 * W_DEF + CNT_W_DEF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/err_stats_acc.sv
// Stage-2 datapath: squares the registered absolute error and folds it into the frame statistics.
module err_stats_acc
    import approx_err_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int SAE_W = W + CNT_W,
    parameter int SSE_W = 2 * W + CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [W-1:0]     i_d,
    input  logic             i_ne,
    output logic [CNT_W-1:0] o_err_count,
    output logic [SAE_W-1:0] o_sae,
    output logic [SSE_W-1:0] o_sse,
    output logic [W-1:0]     o_max_ae
);

    logic [2*W-1:0]   w_sq;
    logic [CNT_W-1:0] r_err_count;
    logic [SAE_W-1:0] r_sae;
    logic [SSE_W-1:0] r_sse;
    logic [W-1:0]     r_max_ae;

    // Full-width operands so the square never truncates.
    assign w_sq = {{W{1'b0}}, i_d} * {{W{1'b0}}, i_d};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_count <= '0;
            r_sae       <= '0;
            r_sse       <= '0;
            r_max_ae    <= '0;
        end else if (i_clr) begin
            r_err_count <= '0;
            r_sae       <= '0;
            r_sse       <= '0;
            r_max_ae    <= '0;
        end else if (i_en) begin
            r_err_count <= r_err_count + CNT_W'(i_ne);
            r_sae       <= r_sae + SAE_W'(i_d);
            r_sse       <= r_sse + SSE_W'(w_sq);
            if (i_d > r_max_ae) begin
                r_max_ae <= i_d;
            end
        end
    end

    assign o_err_count = r_err_count;
    assign o_sae       = r_sae;
    assign o_sse       = r_sse;
    assign o_max_ae    = r_max_ae;

endmodule

// File: rtl/approx_err_accum.sv
// Frame-based error statistics for approximate products: FSM, sample counter, stage-1 |diff| and handshakes.
// Both ports follow valid/ready: a transfer happens on the rising edge where valid and ready are both high;
// ready/valid outputs are pure functions of registered state and never look at the partner's signal.
module approx_err_accum
    import approx_err_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int SAE_W = W + CNT_W,
    parameter int SSE_W = 2 * W + CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] n_samples,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     approx,
    input  logic [W-1:0]     exact,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CNT_W-1:0] err_count,
    output logic [SAE_W-1:0] sae,
    output logic [SSE_W-1:0] sse,
    output logic [W-1:0]     max_ae,
    output logic [1:0]       dbg_state
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           r_state;
    logic [CNT_W-1:0] r_n;
    logic [CNT_W-1:0] r_cnt;
    logic             r_s1_valid;
    logic             r_s1_ne;
    logic [W-1:0]     r_s1_d;

    logic             w_accept;
    logic             w_start_ok;
    logic             w_last;
    logic [W-1:0]     w_d;

    assign in_ready   = (r_state == ST_RUN) && (r_cnt < r_n);
    assign w_accept   = in_valid && in_ready;
    assign w_start_ok = (r_state == ST_IDLE) && start;
    assign w_last     = w_accept && (r_cnt == r_n - CNT_ONE);
    assign w_d        = (approx > exact) ? (approx - exact) : (exact - approx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_n     <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_n     <= n_samples;
                        r_cnt   <= '0;
                        r_state <= (n_samples == '0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_accept) begin
                        r_cnt <= r_cnt + CNT_ONE;
                        if (w_last) begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: r_state <= ST_DONE;
                ST_DONE: begin
                    if (res_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Stage 1: capture |exact - approx| and the mismatch flag for each accepted sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_ne    <= 1'b0;
            r_s1_d     <= '0;
        end else if (w_start_ok) begin
            r_s1_valid <= 1'b0;
            r_s1_ne    <= 1'b0;
            r_s1_d     <= '0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_d  <= w_d;
                r_s1_ne <= (approx != exact);
            end
        end
    end

    err_stats_acc #(
        .W     (W),
        .CNT_W (CNT_W),
        .SAE_W (SAE_W),
        .SSE_W (SSE_W)
    ) u_acc (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clr       (w_start_ok),
        .i_en        (r_s1_valid),
        .i_d         (r_s1_d),
        .i_ne        (r_s1_ne),
        .o_err_count (err_count),
        .o_sae       (sae),
        .o_sse       (sse),
        .o_max_ae    (max_ae)
    );

    assign busy      = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign res_valid = (r_state == ST_DONE);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_approx_err_accum.sv
// Bench for approx_err_accum: frame driver, reference statistics model and result scoreboard.
module tb_approx_err_accum;
    import approx_err_pkg::*;

    typedef struct packed {
        logic [15:0] cnt;
        logic [31:0] sae;
        logic [47:0] sse;
        logic [15:0] mx;
    } res_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] n_samples;
    logic        busy;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] approx;
    logic [15:0] exact;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] err_count;
    logic [31:0] sae;
    logic [47:0] sse;
    logic [15:0] max_ae;
    logic [1:0]  dbg_state;

    int   n_checks = 0;
    int   n_fail   = 0;
    res_t exp_q[$];
    int   a_q[$];
    int   e_q[$];
    res_t last_exp;

    approx_err_accum dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .n_samples (n_samples),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .approx    (approx),
        .exact     (exact),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .err_count (err_count),
        .sae       (sae),
        .sse       (sse),
        .max_ae    (max_ae),
        .dbg_state (dbg_state)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: compares on the result handshake, and checks stability while results are held.
    res_t cur;
    res_t prev_vals;
    logic prev_rv = 1'b0;
    always @(negedge clk) begin
        cur = '{cnt: err_count, sae: sae, sse: sse, mx: max_ae};
        if (!rst_n) begin
            prev_rv = 1'b0;
        end else begin
            if (res_valid && prev_rv) begin
                check("res_stable", cur, prev_vals);
            end
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    res_t e;
                    e = exp_q.pop_front();
                    check("err_count", cur.cnt, e.cnt);
                    check("sae", cur.sae, e.sae);
                    check("sse", cur.sse, e.sse);
                    check("max_ae", cur.mx, e.mx);
                end
            end
            prev_rv   = res_valid;
            prev_vals = cur;
        end
    end

    // Reference model: statistics from signed differences with plain integer arithmetic.
    function automatic res_t model(input int n);
        longint s_sae = 0;
        longint s_sse = 0;
        longint mx    = 0;
        longint cnt   = 0;
        res_t r;
        for (int i = 0; i < n; i++) begin
            longint diff = longint'(e_q[i]) - longint'(a_q[i]);
            longint ad   = (diff < 0) ? -diff : diff;
            if (diff != 0) cnt++;
            s_sae += ad;
            s_sse += diff * diff;
            if (ad > mx) mx = ad;
        end
        r.cnt = cnt[15:0];
        r.sae = s_sae[31:0];
        r.sse = s_sse[47:0];
        r.mx  = mx[15:0];
        return r;
    endfunction

    task automatic add_sample(input int a, input int e);
        a_q.push_back(a);
        e_q.push_back(e);
    endtask

    // Driver: runs one frame from a_q/e_q. Entered and left just after a rising edge.
    task automatic run_frame(input int n, input bit gaps, input int hold, input bit poke);
        int  idx   = 0;
        int  cyc   = 0;
        int  lat   = 0;
        bit  tog   = 1'b1;
        bit  first = 1'b1;
        bit  acc;
        res_t e;
        e = model(n);
        exp_q.push_back(e);
        last_exp = e;
        start     = 1'b1;
        n_samples = 16'(n);
        @(posedge clk); #1;
        start = 1'b0;
        while (idx < n && cyc < 200) begin
            in_valid  = gaps ? tog : 1'b1;
            approx    = 16'(a_q[idx]);
            exact     = 16'(e_q[idx]);
            start     = poke && (cyc == 2);
            n_samples = (poke && cyc == 2) ? 16'd7 : 16'(n);
            @(negedge clk);
            if (first) begin
                check("in_ready_after_start", in_ready, 1);
                first = 1'b0;
            end
            acc = in_valid & in_ready;
            @(posedge clk); #1;
            if (acc) idx++;
            tog = ~tog;
            cyc++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        if (idx < n) check("feed_timeout", idx, n);
        @(negedge clk);
        while (!res_valid && lat < 20) begin
            lat++;
            @(negedge clk);
        end
        check("res_latency", lat, (n == 0) ? 0 : 1);
        check("in_ready_in_done", in_ready, 0);
        check("busy_in_done", busy, 0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            start     = poke && (i == 1);
            n_samples = 16'd3;
        end
        @(posedge clk); #1;
        start     = 1'b0;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        @(negedge clk);
        check("res_valid_after_ack", res_valid, 0);
        check("busy_after_ack", busy, 0);
        check("sae_kept_in_idle", sae, last_exp.sae);
        @(posedge clk); #1;
        a_q.delete();
        e_q.delete();
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        n_samples = '0;
        in_valid  = 1'b0;
        approx    = '0;
        exact     = '0;
        res_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_state", dbg_state, ST_IDLE);
        check("rst_outputs", {err_count, sae, sse, max_ae}, '0);
        check("rst_handshake", {busy, in_ready, res_valid}, 3'b000);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        add_sample(16'h0010, 16'h0010);
        run_frame(1, 1'b0, 0, 1'b0);

        add_sample(100, 103);
        add_sample(50, 40);
        add_sample(7, 7);
        run_frame(3, 1'b0, 1, 1'b0);

        add_sample(0, 16'hFFFF);
        add_sample(0, 16'hFFFF);
        run_frame(2, 1'b0, 0, 1'b0);

        add_sample(100, 103);
        add_sample(50, 40);
        add_sample(7, 7);
        add_sample(1000, 2);
        run_frame(4, 1'b1, 5, 1'b1);

        run_frame(0, 1'b0, 2, 1'b0);

        // Partial frame interrupted by reset: nothing is queued for it.
        start     = 1'b1;
        n_samples = 16'd4;
        @(posedge clk); #1;
        start    = 1'b0;
        in_valid = 1'b1;
        approx   = 16'd1;
        exact    = 16'd200;
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        check("midrst_outputs", {err_count, sae, sse, max_ae}, '0);
        check("midrst_handshake", {busy, in_ready, res_valid}, 3'b000);
        check("midrst_state", dbg_state, ST_IDLE);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        add_sample(5, 9);
        run_frame(1, 1'b0, 0, 1'b0);

        for (int f = 0; f < 8; f++) begin
            int n;
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) begin
                int a;
                int e;
                a = $urandom_range(0, 65535);
                e = ($urandom_range(0, 3) == 0) ? a : $urandom_range(0, 65535);
                add_sample(a, e);
            end
            run_frame(n, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b0);
        end

        repeat (2) @(posedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
